pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit processor.
- Sequences fetch/decode/execute and drives the PC write enable and PC source select consumed by the PC register.
- Also drives IR, memory, register-file and ALU controls.
- Handles a memory ready handshake with timeout, and counts retired instructions.

Parameters:
WAIT_LIMIT, 15, max cycles a memory state waits for input_Seq_memReady before faulting (1..255)
COUNT_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST_N  input  1  synchronous active-low reset, sampled on rising CLK
input_Seq_opcode  input  4  IR[15:12], stable from DECODE until return to FETCH
input_Seq_zero  input  1  ALU zero flag (combinational, same cycle)
input_Seq_memReady  input  1  memory completes access this cycle
output_Seq_PCWrite  output  1  PC load enable
output_Seq_PCSource  output  2  00 ALU result (PC+1), 01 ALUOut (branch target), 10 jump target
output_Seq_IRWrite  output  1  IR load enable
output_Seq_memRead  output  1  memory read request
output_Seq_memWrite  output  1  memory write request
output_Seq_IorD  output  1  0 address=PC, 1 address=ALUOut
output_Seq_regWrite  output  1  register file write enable
output_Seq_memToReg  output  1  0 ALUOut, 1 MDR
output_Seq_regDst  output  1  1 when opcode==0x0 (R-type), else 0
output_Seq_ALUSrcA  output  1  0 PC, 1 reg A
output_Seq_ALUSrcB  output  2  00 reg B, 01 const 1, 10 sign-ext imm
output_Seq_ALUOp  output  2  00 add, 01 sub, 10 funct
output_Seq_state  output  4  current state encoding
output_Seq_illegal  output  1  pulse: undefined opcode in DECODE
output_Seq_halted  output  1  high in HALT
output_Seq_memFault  output  1  sticky: memory timeout occurred
output_Seq_retired  output  COUNT_W  instructions retired

Behaviour:
- One clock, CLK. Reset is synchronous and active-low: RST_N=0 at a rising CLK edge sets state to RESET (0), wait counter to 0, retired to 0 and memFault to 0.
- In RESET all control outputs are 0. RESET goes to FETCH on the next edge after RST_N=1.
- Reset asserted mid-instruction aborts the instruction immediately. No pending write is completed.
- State encoding: RESET=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ALU_WB=5, MEM_ADDR=6, MEM_READ=7, MEM_WB=8, MEM_WRITE=9, BRANCH=10, JUMP=11, HALT=12. Codes 13..15 go to RESET.
- Controls are a Moore decode of state. Exceptions: PCWrite/IRWrite are gated by memReady in FETCH, and PCWrite is gated by zero in BRANCH. Unlisted outputs are 0.
- FETCH: memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=memReady. Goes to DECODE on memReady, else stays.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute). Next state by opcode:
  - 0x0 -> EXEC_R
  - 0x1 -> EXEC_I
  - 0x2 or 0x3 -> MEM_ADDR
  - 0x4 or 0x5 -> BRANCH
  - 0x6 -> JUMP
  - 0xF -> HALT
  - other -> FETCH, with illegal=1 this cycle and retired not incremented
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ALU_WB.
- ALU_WB: regWrite=1, memToReg=0. Goes to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for 0x2, MEM_WRITE for 0x3.
- MEM_READ: memRead=1, IorD=1. Goes to MEM_WB on memReady.
- MEM_WB: regWrite=1, memToReg=1. Goes to FETCH.
- MEM_WRITE: memWrite=1, IorD=1. Goes to FETCH on memReady.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCWrite=zero for 0x4, ~zero for 0x5. Goes to FETCH.
- JUMP: PCSource=10, PCWrite=1. Goes to FETCH.
- HALT: halted=1, all controls 0. Leaves only via reset.
- Wait counter: cleared on entry to FETCH, MEM_READ and MEM_WRITE. Increments each cycle spent in one of these states with memReady=0. On the cycle memReady=0 and the counter equals WAIT_LIMIT, next state is HALT and memFault is set (sticky until reset).
- memReady=1 on the same cycle the limit is reached counts as success.
- retired increments by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WRITE (on its completing cycle), BRANCH or JUMP. It wraps from all-ones to 0. It does not increment on HALT entry.
- Latencies (cycles, memReady immediate):
  - R/I-type: 4
  - LW: 5
  - SW: 4
  - branch/jump: 3

Test Plan:
- RST_N=0 two edges, then 1 -> state 0 then 1. All controls 0 in RESET, retired=0.
- opcode 0x0, memReady=1 -> states 1,2,3,5,1. PCWrite=1 only in FETCH, regWrite=1 only in ALU_WB, regDst=1, retired=1.
- LW opcode 0x2, memReady held 0 for 3 cycles in MEM_READ -> stays state 7 for 4 cycles, IorD=1 throughout, then MEM_WB with memToReg=1.
- BEQ 0x4: zero=1 -> PCWrite=1, PCSource=01 in BRANCH. Repeat with zero=0 -> PCWrite=0. BNE 0x5 with zero=0 -> PCWrite=1.
- memReady stuck 0 in FETCH with WAIT_LIMIT=15 -> HALT after 16 cycles, memFault=1, halted=1. Only RST_N=0 recovers, and it clears memFault.
- opcode 0x9 -> illegal=1 for one cycle in DECODE, back to FETCH, retired unchanged. RST_N=0 asserted during MEM_WRITE -> memWrite drops after that edge, state=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the 16-bit processor.
// Drives PC, IR, memory, register-file and ALU controls; times out stalled memory accesses.
module pc_sequencer #(
  parameter int WAIT_LIMIT = 15,
  parameter int COUNT_W    = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [3:0]         input_Seq_opcode,
  input  logic               input_Seq_zero,
  input  logic               input_Seq_memReady,
  output logic               output_Seq_PCWrite,
  output logic [1:0]         output_Seq_PCSource,
  output logic               output_Seq_IRWrite,
  output logic               output_Seq_memRead,
  output logic               output_Seq_memWrite,
  output logic               output_Seq_IorD,
  output logic               output_Seq_regWrite,
  output logic               output_Seq_memToReg,
  output logic               output_Seq_regDst,
  output logic               output_Seq_ALUSrcA,
  output logic [1:0]         output_Seq_ALUSrcB,
  output logic [1:0]         output_Seq_ALUOp,
  output logic [3:0]         output_Seq_state,
  output logic               output_Seq_illegal,
  output logic               output_Seq_halted,
  output logic               output_Seq_memFault,
  output logic [COUNT_W-1:0] output_Seq_retired
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  state_t state, next_state;
  logic [7:0] wait_cnt;
  logic mem_fault;
  logic waiting_state, timeout, retire, op_legal;

  assign waiting_state = state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  assign timeout  = waiting_state && !input_Seq_memReady && (wait_cnt == 8'(WAIT_LIMIT));
  assign op_legal = input_Seq_opcode inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};

  always_comb begin
    next_state = S_RESET;
    case (state)
      S_RESET:     next_state = S_FETCH;
      S_FETCH:     next_state = input_Seq_memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (input_Seq_opcode)
          4'h0:       next_state = S_EXEC_R;
          4'h1:       next_state = S_EXEC_I;
          4'h2, 4'h3: next_state = S_MEM_ADDR;
          4'h4, 4'h5: next_state = S_BRANCH;
          4'h6:       next_state = S_JUMP;
          4'hF:       next_state = S_HALT;
          default:    next_state = S_FETCH;
        endcase
      end
      S_EXEC_R:    next_state = S_ALU_WB;
      S_EXEC_I:    next_state = S_ALU_WB;
      S_ALU_WB:    next_state = S_FETCH;
      S_MEM_ADDR:  next_state = (input_Seq_opcode == 4'h2) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state = input_Seq_memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: next_state = input_Seq_memReady ? S_FETCH : S_MEM_WRITE;
      S_BRANCH:    next_state = S_FETCH;
      S_JUMP:      next_state = S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_RESET;
    endcase
    if (timeout) next_state = S_HALT;
  end

  // Only completed instructions retire; illegal opcodes and HALT entry do not.
  assign retire = (next_state == S_FETCH) &&
                  (state inside {S_ALU_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP});

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state              <= S_RESET;
      wait_cnt           <= 8'd0;
      mem_fault          <= 1'b0;
      output_Seq_retired <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        wait_cnt <= 8'd0;
      else if (waiting_state && !input_Seq_memReady)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout) mem_fault <= 1'b1;
      if (retire) output_Seq_retired <= output_Seq_retired + COUNT_W'(1);
    end
  end

  always_comb begin
    output_Seq_PCWrite  = 1'b0;
    output_Seq_PCSource = 2'b00;
    output_Seq_IRWrite  = 1'b0;
    output_Seq_memRead  = 1'b0;
    output_Seq_memWrite = 1'b0;
    output_Seq_IorD     = 1'b0;
    output_Seq_regWrite = 1'b0;
    output_Seq_memToReg = 1'b0;
    output_Seq_ALUSrcA  = 1'b0;
    output_Seq_ALUSrcB  = 2'b00;
    output_Seq_ALUOp    = 2'b00;
    case (state)
      S_FETCH: begin
        output_Seq_memRead = 1'b1;
        output_Seq_ALUSrcB = 2'b01;
        output_Seq_IRWrite = input_Seq_memReady;
        output_Seq_PCWrite = input_Seq_memReady;
      end
      S_DECODE:    output_Seq_ALUSrcB = 2'b10;
      S_EXEC_R: begin
        output_Seq_ALUSrcA = 1'b1;
        output_Seq_ALUOp   = 2'b10;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        output_Seq_ALUSrcA = 1'b1;
        output_Seq_ALUSrcB = 2'b10;
      end
      S_ALU_WB:    output_Seq_regWrite = 1'b1;
      S_MEM_READ: begin
        output_Seq_memRead = 1'b1;
        output_Seq_IorD    = 1'b1;
      end
      S_MEM_WB: begin
        output_Seq_regWrite = 1'b1;
        output_Seq_memToReg = 1'b1;
      end
      S_MEM_WRITE: begin
        output_Seq_memWrite = 1'b1;
        output_Seq_IorD     = 1'b1;
      end
      S_BRANCH: begin
        output_Seq_ALUSrcA  = 1'b1;
        output_Seq_ALUOp    = 2'b01;
        output_Seq_PCSource = 2'b01;
        output_Seq_PCWrite  = (input_Seq_opcode == 4'h4) ? input_Seq_zero : !input_Seq_zero;
      end
      S_JUMP: begin
        output_Seq_PCSource = 2'b10;
        output_Seq_PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign output_Seq_regDst   = (input_Seq_opcode == 4'h0) && (state != S_RESET) && (state != S_HALT);
  assign output_Seq_illegal  = (state == S_DECODE) && !op_legal;
  assign output_Seq_halted   = (state == S_HALT);
  assign output_Seq_memFault = mem_fault;
  assign output_Seq_state    = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, timeout corner sequences,
// then randomized traffic against an instruction-path reference model.
module tb_pc_sequencer;
  localparam int WAIT_LIMIT = 15;
  localparam int COUNT_W    = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst, alu_src_a;
  logic illegal, halted, mem_fault;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
  logic [COUNT_W-1:0] retired;

  pc_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .COUNT_W(COUNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .input_Seq_opcode(opcode), .input_Seq_zero(zero), .input_Seq_memReady(mem_ready),
    .output_Seq_PCWrite(pc_write), .output_Seq_PCSource(pc_source), .output_Seq_IRWrite(ir_write),
    .output_Seq_memRead(mem_read), .output_Seq_memWrite(mem_write), .output_Seq_IorD(iord),
    .output_Seq_regWrite(reg_write), .output_Seq_memToReg(mem_to_reg), .output_Seq_regDst(reg_dst),
    .output_Seq_ALUSrcA(alu_src_a), .output_Seq_ALUSrcB(alu_src_b), .output_Seq_ALUOp(alu_op),
    .output_Seq_state(state), .output_Seq_illegal(illegal), .output_Seq_halted(halted),
    .output_Seq_memFault(mem_fault), .output_Seq_retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic pcw; logic [1:0] pcs; logic irw, mr, mw, iord, rw, m2r, rdst, asa;
    logic [1:0] asb, aop; logic ill, halted;
  } ctl_t;

  typedef struct {
    logic rst_n; logic [3:0] op; logic z; logic rdy;
    logic [3:0] st; logic [10:0] ctl; logic [COUNT_W-1:0] ret;
  } vec_t;

  int checks = 0, failures = 0;
  vec_t vecs[$];
  ctl_t ctl_tab [16];

  // Reference model: expected state, instruction path still to walk, stall count.
  int m_state, m_wait;
  int m_path[$];
  logic [COUNT_W-1:0] m_ret;
  logic m_fault;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] o, input logic z, input logic rdy);
    RST_N = r; opcode = o; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic vec_t mkv(logic r, logic [3:0] o, logic z, logic rdy, logic [3:0] s,
                               logic [10:0] c, logic [COUNT_W-1:0] rt);
    vec_t v;
    v.rst_n = r; v.op = o; v.z = z; v.rdy = rdy; v.st = s; v.ctl = c; v.ret = rt;
    return v;
  endfunction

  function automatic logic [10:0] dutSubset();
    return {pc_write, pc_source, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst, illegal};
  endfunction

  function automatic ctl_t dutCtl();
    return ctl_t'({pc_write, pc_source, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg,
                   reg_dst, alu_src_a, alu_src_b, alu_op, illegal, halted});
  endfunction

  function automatic bit legalOp(logic [3:0] o);
    return (o <= 4'h6) || (o == 4'hF);
  endfunction

  function automatic ctl_t modelCtl(logic [3:0] o, logic z, logic rdy);
    ctl_t c = ctl_tab[m_state];
    if (m_state == 1) begin c.pcw = rdy; c.irw = rdy; end
    if (m_state == 10) c.pcw = (o == 4'h4) ? z : !z;
    c.rdst   = (o == 4'h0) && (m_state != 0) && (m_state != 12);
    c.ill    = (m_state == 2) && !legalOp(o);
    c.halted = (m_state == 12);
    return c;
  endfunction

  // States visited after FETCH for each opcode; an exhausted path returns to FETCH.
  task automatic loadPath(input logic [3:0] o);
    case (o)
      4'h0:       m_path = '{2, 3, 5};
      4'h1:       m_path = '{2, 4, 5};
      4'h2:       m_path = '{2, 6, 7, 8};
      4'h3:       m_path = '{2, 6, 9};
      4'h4, 4'h5: m_path = '{2, 10};
      4'h6:       m_path = '{2, 11};
      4'hF:       m_path = '{2, 12};
      default:    m_path = '{2};
    endcase
  endtask

  task automatic modelStep(input logic r, input logic [3:0] o, input logic rdy);
    if (!r) begin
      m_state = 0; m_wait = 0; m_ret = '0; m_fault = 1'b0; m_path.delete();
    end else if (m_state == 0) begin
      m_state = 1; m_wait = 0;
    end else if (m_state != 12) begin
      if ((m_state == 1 || m_state == 7 || m_state == 9) && !rdy) begin
        if (m_wait == WAIT_LIMIT) begin m_state = 12; m_fault = 1'b1; end
        else m_wait++;
      end else begin
        if (m_state == 1) begin loadPath(o); m_state = m_path.pop_front(); end
        else if (m_path.size() > 0) m_state = m_path.pop_front();
        else begin m_state = 1; if (legalOp(o)) m_ret++; end
        m_wait = 0;
      end
    end
  endtask

  initial begin
    int stall_left;
    logic r, z, rdy;
    logic [3:0] o;

    for (int i = 0; i < 16; i++) ctl_tab[i] = '0;
    ctl_tab[1].mr = 1;  ctl_tab[1].asb = 2'b01;
    ctl_tab[2].asb = 2'b10;
    ctl_tab[3].asa = 1; ctl_tab[3].aop = 2'b10;
    ctl_tab[4].asa = 1; ctl_tab[4].asb = 2'b10;
    ctl_tab[5].rw = 1;
    ctl_tab[6].asa = 1; ctl_tab[6].asb = 2'b10;
    ctl_tab[7].mr = 1;  ctl_tab[7].iord = 1;
    ctl_tab[8].rw = 1;  ctl_tab[8].m2r = 1;
    ctl_tab[9].mw = 1;  ctl_tab[9].iord = 1;
    ctl_tab[10].asa = 1; ctl_tab[10].aop = 2'b01; ctl_tab[10].pcs = 2'b01;
    ctl_tab[11].pcw = 1; ctl_tab[11].pcs = 2'b10;

    // Fields: {PCWrite, PCSource, IRWrite, memRead, memWrite, IorD, regWrite, memToReg, regDst, illegal}
    vecs.push_back(mkv(0, 4'h0, 0, 1, 0,  11'b0, 0));
    vecs.push_back(mkv(1, 4'h0, 0, 1, 0,  11'b0, 0));
    vecs.push_back(mkv(1, 4'h0, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_1_0, 0));
    vecs.push_back(mkv(1, 4'h0, 0, 1, 2,  11'b0_00_0_0_0_0_0_0_1_0, 0));
    vecs.push_back(mkv(1, 4'h0, 0, 1, 3,  11'b0_00_0_0_0_0_0_0_1_0, 0));
    vecs.push_back(mkv(1, 4'h0, 0, 1, 5,  11'b0_00_0_0_0_0_1_0_1_0, 0));
    vecs.push_back(mkv(1, 4'h2, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 1));
    vecs.push_back(mkv(1, 4'h2, 0, 1, 2,  11'b0, 1));
    vecs.push_back(mkv(1, 4'h2, 0, 1, 6,  11'b0, 1));
    vecs.push_back(mkv(1, 4'h2, 0, 0, 7,  11'b0_00_0_1_0_1_0_0_0_0, 1));
    vecs.push_back(mkv(1, 4'h2, 0, 0, 7,  11'b0_00_0_1_0_1_0_0_0_0, 1));
    vecs.push_back(mkv(1, 4'h2, 0, 0, 7,  11'b0_00_0_1_0_1_0_0_0_0, 1));
    vecs.push_back(mkv(1, 4'h2, 0, 1, 7,  11'b0_00_0_1_0_1_0_0_0_0, 1));
    vecs.push_back(mkv(1, 4'h2, 0, 1, 8,  11'b0_00_0_0_0_0_1_1_0_0, 1));
    vecs.push_back(mkv(1, 4'h4, 1, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 2));
    vecs.push_back(mkv(1, 4'h4, 1, 1, 2,  11'b0, 2));
    vecs.push_back(mkv(1, 4'h4, 1, 1, 10, 11'b1_01_0_0_0_0_0_0_0_0, 2));
    vecs.push_back(mkv(1, 4'h4, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 3));
    vecs.push_back(mkv(1, 4'h4, 0, 1, 2,  11'b0, 3));
    vecs.push_back(mkv(1, 4'h4, 0, 1, 10, 11'b0_01_0_0_0_0_0_0_0_0, 3));
    vecs.push_back(mkv(1, 4'h5, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 4));
    vecs.push_back(mkv(1, 4'h5, 0, 1, 2,  11'b0, 4));
    vecs.push_back(mkv(1, 4'h5, 0, 1, 10, 11'b1_01_0_0_0_0_0_0_0_0, 4));
    vecs.push_back(mkv(1, 4'h9, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 5));
    vecs.push_back(mkv(1, 4'h9, 0, 1, 2,  11'b0_00_0_0_0_0_0_0_0_1, 5));
    vecs.push_back(mkv(1, 4'h3, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 5));
    vecs.push_back(mkv(1, 4'h3, 0, 1, 2,  11'b0, 5));
    vecs.push_back(mkv(1, 4'h3, 0, 1, 6,  11'b0, 5));
    vecs.push_back(mkv(1, 4'h3, 0, 0, 9,  11'b0_00_0_0_1_1_0_0_0_0, 5));
    vecs.push_back(mkv(0, 4'h3, 0, 0, 9,  11'b0_00_0_0_1_1_0_0_0_0, 5));
    vecs.push_back(mkv(1, 4'h6, 0, 1, 0,  11'b0, 0));
    vecs.push_back(mkv(1, 4'h6, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 0));
    vecs.push_back(mkv(1, 4'h6, 0, 1, 2,  11'b0, 0));
    vecs.push_back(mkv(1, 4'h6, 0, 1, 11, 11'b1_10_0_0_0_0_0_0_0_0, 0));
    vecs.push_back(mkv(1, 4'h6, 0, 1, 1,  11'b1_00_1_1_0_0_0_0_0_0, 1));

    applyStimulus(0, 4'h0, 0, 1);
    tick();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].op, vecs[i].z, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      checkOutput($sformatf("vec%0d_ctl", i), 32'(dutSubset()), 32'(vecs[i].ctl));
      checkOutput($sformatf("vec%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
      tick();
    end

    // FETCH stall: 16 cycles without memReady faults into HALT; only reset recovers.
    applyStimulus(0, 4'h0, 0, 0); tick();
    applyStimulus(1, 4'h0, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 4'h0, 0, 0);
      checkOutput("timeout_wait_state", 32'(state), 32'd1);
      tick();
    end
    checkOutput("timeout_state", 32'(state), 32'd12);
    checkOutput("timeout_halted", 32'(halted), 32'd1);
    checkOutput("timeout_memfault", 32'(mem_fault), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'h0, 0, 1);
      checkOutput("halt_ctl_quiet", 32'(dutSubset()), 32'd0);
      tick();
      checkOutput("halt_sticky", 32'(state), 32'd12);
    end
    applyStimulus(0, 4'h0, 0, 1); tick();
    checkOutput("recover_state", 32'(state), 32'd0);
    checkOutput("recover_memfault", 32'(mem_fault), 32'd0);
    checkOutput("recover_halted", 32'(halted), 32'd0);

    // memReady arriving exactly when the counter hits the limit is a success.
    applyStimulus(1, 4'h1, 0, 0); tick();
    for (int i = 0; i < 15; i++) begin applyStimulus(1, 4'h1, 0, 0); tick(); end
    applyStimulus(1, 4'h1, 0, 1);
    checkOutput("limit_ready_state", 32'(state), 32'd1);
    checkOutput("limit_ready_pcwrite", 32'(pc_write), 32'd1);
    tick();
    checkOutput("limit_ready_decode", 32'(state), 32'd2);
    checkOutput("limit_ready_nofault", 32'(mem_fault), 32'd0);

    // Randomized traffic against the reference model.
    applyStimulus(0, 4'h0, 0, 1);
    modelStep(0, 4'h0, 1);
    tick();
    stall_left = 0;
    o = 4'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = ($urandom_range(0, 149) != 0);
      z = 1'($urandom_range(0, 1));
      if (stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        rdy = 1'b0; stall_left = $urandom_range(8, 20);
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (m_state == 0 || m_state == 1 || m_state == 12) begin
        o = 4'($urandom_range(0, 15));
        if (o == 4'hF && $urandom_range(0, 3) != 0) o = 4'($urandom_range(0, 14));
      end
      applyStimulus(r, o, z, rdy);
      checkOutput("rand_state", 32'(state), 32'(m_state));
      checkOutput("rand_ctl", 32'(dutCtl()), 32'(modelCtl(o, z, rdy)));
      checkOutput("rand_retired", 32'(retired), 32'(m_ret));
      checkOutput("rand_memfault", 32'(mem_fault), 32'(m_fault));
      modelStep(r, o, rdy);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
